reg_skid_buf: RTL

REG_SKID_BUF -- requirements
Module: reg_skid_buf

---
 rtl/reg_skid_buf.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reg_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : reg_skid_buf
// Purpose  : Two-entry elastic pipeline register (main/head register plus a
//            skid register) with valid/ready handshakes on both sides.
//            Every handshake output is decoded purely from the state
//            register, so neither in_valid nor out_ready has a combinational
//            path to in_ready or out_valid. Upstream and downstream timing
//            are therefore fully decoupled while full throughput is kept.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W      payload width in bits
//   PRESET_VAL  value loaded into main and skid registers on reset
// Ports
//   clk        in   1       sole clock, rising edge
//   srst       in   1       synchronous active-high reset (highest priority)
//   flush      in   1       synchronous discard of all held entries
//   in_valid   in   1       upstream offers in_data
//   in_ready   out  1       block accepts in_data this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a valid entry
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  DATA_W  head-of-buffer payload (always the main register)
//   level      out  2       entries held: 0, 1 or 2
// ============================================================================
module reg_skid_buf #(
  parameter int                  DATA_W     = 32,
  parameter logic [DATA_W-1:0]   PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  // --------------------------------------------------------------------------
  // State encoding: the code of each state equals the number of entries held,
  // which makes the level decode trivial and readable.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;

  logic              in_fire;
  logic              out_fire;

  // --------------------------------------------------------------------------
  // Handshake decode -- a function of the state register only.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    level     = 2'd0;
    unique case (state)
      EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        level     = 2'd0;
      end
      BUSY: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        level     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        level     = 2'd2;
      end
      default: begin
        // Unreachable encoding: present as empty so nothing is delivered and
        // the state machine recovers on the next edge.
        out_valid = 1'b0;
        in_ready  = 1'b1;
        level     = 2'd0;
      end
    endcase
  end

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // Head of buffer is always the main register, valid or not.
  assign out_data = main_reg;

  // --------------------------------------------------------------------------
  // State machine and data path.
  // Priority: srst > flush > normal transfers.
  // A flush drops the state to EMPTY but leaves both data registers alone, so
  // out_data keeps showing the last head value while out_valid is low. An
  // out_fire coinciding with flush needs no special handling: the entry was
  // consumed downstream and everything else is discarded anyway.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= EMPTY;
      main_reg <= PRESET_VAL;
      skid_reg <= PRESET_VAL;
    end else if (flush) begin
      state    <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state    <= BUSY;
            main_reg <= in_data;
          end
        end

        BUSY: begin
          if (in_fire && out_fire) begin
            // Head leaves and the new entry takes its place: level stays 1.
            main_reg <= in_data;
          end else if (in_fire) begin
            // Head is stalled, park the new entry behind it.
            state    <= FULL;
            skid_reg <= in_data;
          end else if (out_fire) begin
            // main_reg intentionally keeps the departed value.
            state    <= EMPTY;
          end
        end

        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            state    <= BUSY;
            main_reg <= skid_reg;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
